// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl -- program-counter sequencer for the ctr block.
//
// Each cycle this block decides what the external counter does next: hold,
// count up, count down, or load a jump address. It also keeps a small return
// stack for calls and interrupts.
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-low reset
//   pc_in             current counter value (ctrOut of ctr)
//   stall             hold the PC this cycle
//   br_req/br_tgt     branch request and target
//   call_req/call_tgt subroutine call and target
//   ret_req           return (pop the stack)
//   rewind            step the PC back by one
//   irq               level interrupt request
//   halt_req/resume   enter and leave HALT
//   ctr_en/dir/jmp    counter enable, direction (1=up), load
//   ctr_jmpLoc        counter load address (0 when not loading)
//   irq_ack           one-cycle pulse when an interrupt is taken
//   halted            high while in HALT
//   stk_err           sticky stack overflow/underflow flag
module pc_seq_ctrl #(
   parameter int            AW      = 10,
   parameter int            DEPTH   = 4,
   parameter logic [AW-1:0] RST_VEC = 10'd0,
   parameter logic [AW-1:0] IRQ_VEC = 10'd16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] pc_in,
   input  logic          stall,
   input  logic          br_req,
   input  logic [AW-1:0] br_tgt,
   input  logic          call_req,
   input  logic [AW-1:0] call_tgt,
   input  logic          ret_req,
   input  logic          rewind,
   input  logic          irq,
   input  logic          halt_req,
   input  logic          resume,
   output logic          ctr_en,
   output logic          ctr_dir,
   output logic          ctr_jmp,
   output logic [AW-1:0] ctr_jmpLoc,
   output logic          irq_ack,
   output logic          halted,
   output logic          stk_err
);

   localparam int             SPW      = $clog2(DEPTH + 1);
   localparam int             IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [SPW-1:0] FULL_CNT = SPW'(DEPTH);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t         state_q, state_d;
   logic [SPW-1:0] sp_q, sp_d;
   logic           in_isr_q, in_isr_d;
   logic           stk_err_q, stk_err_d;
   logic [AW-1:0]  stk_addr_q [DEPTH];
   logic [AW-1:0]  stk_addr_d [DEPTH];
   logic [DEPTH-1:0] stk_tag_q, stk_tag_d;

   logic          full, empty, irq_take;
   logic [IW-1:0] wr_idx, top_idx;
   logic [AW-1:0] pc_nxt;
   logic          do_push, push_tag, do_pop;
   logic          en_c, dir_c, jmp_c, ack_c, halted_c;
   logic [AW-1:0] loc_c;

   assign full     = (sp_q == FULL_CNT);
   assign empty    = (sp_q == '0);
   assign irq_take = irq & ~in_isr_q;
   // Return address wraps naturally at AW bits.
   assign pc_nxt   = pc_in + 1'b1;
   // Indices are only used when the stack is not full (push) or not empty
   // (pop), so the truncation below never aliases a live slot.
   assign wr_idx   = IW'(sp_q);
   assign top_idx  = IW'(sp_q - 1'b1);

   always_comb begin
      state_d    = state_q;
      sp_d       = sp_q;
      in_isr_d   = in_isr_q;
      stk_err_d  = stk_err_q;
      stk_addr_d = stk_addr_q;
      stk_tag_d  = stk_tag_q;
      do_push    = 1'b0;
      push_tag   = 1'b0;
      do_pop     = 1'b0;
      en_c       = 1'b0;
      dir_c      = 1'b1;
      jmp_c      = 1'b0;
      loc_c      = '0;
      ack_c      = 1'b0;
      halted_c   = 1'b0;

      case (state_q)
         BOOT: begin
            jmp_c   = 1'b1;
            loc_c   = RST_VEC;
            state_d = RUN;
         end

         RUN: begin
            if (halt_req) begin
               state_d = HALT;
            end else if (stall) begin
               // hold; a level irq simply waits for the next free cycle
            end else if (irq_take) begin
               if (full) begin
                  // irq stays pending at its source; count on
                  stk_err_d = 1'b1;
                  en_c      = 1'b1;
               end else begin
                  do_push  = 1'b1;
                  push_tag = 1'b1;
                  jmp_c    = 1'b1;
                  loc_c    = IRQ_VEC;
                  ack_c    = 1'b1;
                  in_isr_d = 1'b1;
               end
            end else if (ret_req) begin
               if (empty) begin
                  stk_err_d = 1'b1;
                  en_c      = 1'b1;
               end else begin
                  do_pop = 1'b1;
                  jmp_c  = 1'b1;
                  loc_c  = stk_addr_q[top_idx];
               end
            end else if (call_req) begin
               if (full) begin
                  stk_err_d = 1'b1;
                  en_c      = 1'b1;
               end else begin
                  do_push = 1'b1;
                  jmp_c   = 1'b1;
                  loc_c   = call_tgt;
               end
            end else if (br_req) begin
               jmp_c = 1'b1;
               loc_c = br_tgt;
            end else if (rewind) begin
               en_c  = 1'b1;
               dir_c = 1'b0;
            end else begin
               en_c = 1'b1;
            end
         end

         HALT: begin
            halted_c = 1'b1;
            if (irq_take) begin
               if (full) begin
                  // cannot save a return address; remain halted
                  stk_err_d = 1'b1;
               end else begin
                  do_push  = 1'b1;
                  push_tag = 1'b1;
                  jmp_c    = 1'b1;
                  loc_c    = IRQ_VEC;
                  ack_c    = 1'b1;
                  in_isr_d = 1'b1;
                  state_d  = RUN;
               end
            end else if (resume) begin
               state_d = RUN;
            end
         end

         default: state_d = BOOT;
      endcase

      if (do_push) begin
         stk_addr_d[wr_idx] = pc_nxt;
         stk_tag_d[wr_idx]  = push_tag;
         sp_d               = sp_q + 1'b1;
      end
      if (do_pop) begin
         sp_d = sp_q - 1'b1;
         if (stk_tag_q[top_idx]) in_isr_d = 1'b0;
      end

      // Outputs follow reset immediately, not just at the next edge.
      if (!rst) begin
         en_c     = 1'b0;
         dir_c    = 1'b1;
         jmp_c    = 1'b0;
         loc_c    = '0;
         ack_c    = 1'b0;
         halted_c = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= BOOT;
         sp_q      <= '0;
         in_isr_q  <= 1'b0;
         stk_err_q <= 1'b0;
         stk_tag_q <= '0;
         for (int i = 0; i < DEPTH; i++) stk_addr_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         sp_q       <= sp_d;
         in_isr_q   <= in_isr_d;
         stk_err_q  <= stk_err_d;
         stk_tag_q  <= stk_tag_d;
         stk_addr_q <= stk_addr_d;
      end
   end

   assign ctr_en     = en_c;
   assign ctr_dir    = dir_c;
   assign ctr_jmp    = jmp_c;
   assign ctr_jmpLoc = loc_c;
   assign irq_ack    = ack_c;
   assign halted     = halted_c;
   assign stk_err    = stk_err_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl. A behavioural model of the ctr block closes
// the loop (pc_in follows the DUT's ctr_* commands). Each step pushes its
// expected outputs to a scoreboard queue; the entry is popped and compared
// on the following falling edge.
module tb_pc_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] pc_in;
   logic       stall = 0, br_req = 0, call_req = 0, ret_req = 0;
   logic       rewind = 0, irq = 0, halt_req = 0, resume = 0;
   logic [9:0] br_tgt = '0, call_tgt = '0;
   logic       ctr_en, ctr_dir, ctr_jmp, irq_ack, halted, stk_err;
   logic [9:0] ctr_jmpLoc;

   int total = 0;
   int bad   = 0;
   logic [9:0] epc;

   typedef struct {
      string      tag;
      logic [9:0] pc;
      logic       en, dir, jmp;
      logic [9:0] loc;
      logic       ack, hlt, err;
   } exp_t;
   exp_t sb[$];

   pc_seq_ctrl dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .stall(stall),
      .br_req(br_req), .br_tgt(br_tgt), .call_req(call_req),
      .call_tgt(call_tgt), .ret_req(ret_req), .rewind(rewind), .irq(irq),
      .halt_req(halt_req), .resume(resume), .ctr_en(ctr_en),
      .ctr_dir(ctr_dir), .ctr_jmp(ctr_jmp), .ctr_jmpLoc(ctr_jmpLoc),
      .irq_ack(irq_ack), .halted(halted), .stk_err(stk_err)
   );

   always #5 clk = ~clk;

   // ctr block model
   always @(posedge clk or negedge rst) begin
      if (!rst)         pc_in <= '0;
      else if (ctr_jmp) pc_in <= ctr_jmpLoc;
      else if (ctr_en)  pc_in <= ctr_dir ? pc_in + 10'd1 : pc_in - 10'd1;
   end

   task automatic cmp(input string tag, input string f,
                      input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s.%s got=%0h exp=%0h", tag, f, o, e);
      end
   endtask

   task automatic step(input string tag, input logic [9:0] pc,
                       input logic en, input logic dir, input logic jmp,
                       input logic [9:0] loc, input logic ack,
                       input logic hlt, input logic err);
      exp_t x;
      x.tag = tag; x.pc = pc; x.en = en; x.dir = dir; x.jmp = jmp;
      x.loc = loc; x.ack = ack; x.hlt = hlt; x.err = err;
      sb.push_back(x);
      @(negedge clk);
      x = sb.pop_front();
      cmp(x.tag, "pc",      32'(pc_in),      32'(x.pc));
      cmp(x.tag, "en",      32'(ctr_en),     32'(x.en));
      cmp(x.tag, "dir",     32'(ctr_dir),    32'(x.dir));
      cmp(x.tag, "jmp",     32'(ctr_jmp),    32'(x.jmp));
      cmp(x.tag, "loc",     32'(ctr_jmpLoc), 32'(x.loc));
      cmp(x.tag, "ack",     32'(irq_ack),    32'(x.ack));
      cmp(x.tag, "halted",  32'(halted),     32'(x.hlt));
      cmp(x.tag, "stk_err", 32'(stk_err),    32'(x.err));
      @(posedge clk);
      #1;
   endtask

   task automatic inc(input int n, input logic err);
      for (int i = 0; i < n; i++) begin
         step("inc", epc, 1, 1, 0, 10'd0, 0, 0, err);
         epc = epc + 10'd1;
      end
   endtask

   initial begin
      // reset and boot
      step("rst", 10'd0, 0, 1, 0, 10'd0, 0, 0, 0);
      rst = 1'b1;
      step("boot", 10'd0, 0, 1, 1, 10'd0, 0, 0, 0);
      epc = 10'd0;
      inc(5, 0);

      // call / return
      call_req = 1; call_tgt = 10'd69;
      step("call", 10'd5, 0, 1, 1, 10'd69, 0, 0, 0);
      call_req = 0; epc = 10'd69;
      inc(3, 0);
      ret_req = 1;
      step("ret", 10'd72, 0, 1, 1, 10'd6, 0, 0, 0);
      ret_req = 0; epc = 10'd6;
      inc(4, 0);

      // irq beats a branch; held irq does not re-enter
      irq = 1; br_req = 1; br_tgt = 10'd100;
      step("irq_br", 10'd10, 0, 1, 1, 10'd16, 1, 0, 0);
      br_req = 0; epc = 10'd16;
      inc(3, 0);
      irq = 0; ret_req = 1;
      step("isr_ret", 10'd19, 0, 1, 1, 10'd11, 0, 0, 0);
      ret_req = 0;
      irq = 1;
      step("irq2", 10'd11, 0, 1, 1, 10'd16, 1, 0, 0);
      irq = 0; ret_req = 1;
      step("ret2", 10'd16, 0, 1, 1, 10'd12, 0, 0, 0);
      ret_req = 0;

      // stack overflow then underflow
      call_req = 1; call_tgt = 10'd200;
      step("call1", 10'd12, 0, 1, 1, 10'd200, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         step("callN", 10'd200, 0, 1, 1, 10'd200, 0, 0, 0);
      step("call5", 10'd200, 1, 1, 0, 10'd0, 0, 0, 0);
      call_req = 0;
      ret_req = 1;
      for (int i = 0; i < 3; i++)
         step("retN", 10'd201, 0, 1, 1, 10'd201, 0, 0, 1);
      step("ret4", 10'd201, 0, 1, 1, 10'd13, 0, 0, 1);
      step("ret5", 10'd13, 1, 1, 0, 10'd0, 0, 0, 1);
      ret_req = 0;

      // halt for 20 cycles, then resume
      halt_req = 1;
      step("halt", 10'd14, 0, 1, 0, 10'd0, 0, 0, 1);
      halt_req = 0;
      for (int i = 0; i < 20; i++)
         step("halted", 10'd14, 0, 1, 0, 10'd0, 0, 1, 1);
      resume = 1;
      step("resume", 10'd14, 0, 1, 0, 10'd0, 0, 1, 1);
      resume = 0; epc = 10'd14;
      inc(2, 1);

      // stall beats rewind; rewind wraps below zero
      stall = 1; rewind = 1;
      step("stall_rw", 10'd16, 0, 1, 0, 10'd0, 0, 0, 1);
      stall = 0; rewind = 0;
      br_req = 1; br_tgt = 10'd0;
      step("br0", 10'd16, 0, 1, 1, 10'd0, 0, 0, 1);
      br_req = 0;
      rewind = 1;
      step("rw0", 10'd0, 1, 0, 0, 10'd0, 0, 0, 1);
      rewind = 0;

      // return address wraps: call at 3FF pushes 0
      call_req = 1; call_tgt = 10'd50;
      step("call_wrap", 10'h3FF, 0, 1, 1, 10'd50, 0, 0, 1);
      call_req = 0; ret_req = 1;
      step("ret_wrap", 10'd50, 0, 1, 1, 10'd0, 0, 0, 1);
      ret_req = 0;

      // irq taken from HALT
      halt_req = 1;
      step("halt2", 10'd0, 0, 1, 0, 10'd0, 0, 0, 1);
      halt_req = 0;
      step("halted2", 10'd0, 0, 1, 0, 10'd0, 0, 1, 1);
      irq = 1;
      step("halt_irq", 10'd0, 0, 1, 1, 10'd16, 1, 1, 1);
      step("isr_run", 10'd16, 1, 1, 0, 10'd0, 0, 0, 1);

      // three entries deep inside the ISR, then reset
      call_req = 1; call_tgt = 10'd300;
      step("c_a", 10'd17, 0, 1, 1, 10'd300, 0, 0, 1);
      call_tgt = 10'd400;
      step("c_b", 10'd300, 0, 1, 1, 10'd400, 0, 0, 1);
      call_req = 0; irq = 0;
      rst = 1'b0;
      step("rst_mid", 10'd0, 0, 1, 0, 10'd0, 0, 0, 0);
      rst = 1'b1;
      step("boot2", 10'd0, 0, 1, 1, 10'd0, 0, 0, 0);
      ret_req = 1;
      step("ret_empty", 10'd0, 1, 1, 0, 10'd0, 0, 0, 0);
      ret_req = 0;
      step("err_after", 10'd1, 1, 1, 0, 10'd0, 0, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning), SHALL be: AW, 10, counter/address width; DEPTH, 4, return-stack entries; RST_VEC, 10'd0, boot address; IRQ_VEC, 10'd16, interrupt handler address.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  reset, asynchronous, active-low; 0 = reset asserted.
REQ-004 pc_in  in  AW  current counter value (ctrOut of the ctr block).
REQ-005 stall  in  1  hold PC this cycle.
REQ-006 br_req/br_tgt  in  1/AW  branch request and target.
REQ-007 call_req/call_tgt  in  1/AW  subroutine call and target.
REQ-008 ret_req  in  1  return: pop the stack.
REQ-009 rewind  in  1  step the PC back by one.
REQ-010 irq  in  1  level interrupt request.
REQ-011 halt_req/resume  in  1/1  enter and leave HALT.
REQ-012 ctr_en, ctr_dir, ctr_jmp  out  1 each  drive en, dir and jmp of ctr.
REQ-013 ctr_jmpLoc  out  AW  drives jmpLoc of ctr.
REQ-014 irq_ack  out  1  one-cycle pulse when an interrupt is taken.
REQ-015 halted  out  1  high while in HALT.
REQ-016 stk_err  out  1  sticky overflow/underflow flag.

Function
REQ-017 FSM states SHALL be BOOT, RUN and HALT; reset enters BOOT.
REQ-018 BOOT SHALL last exactly one cycle after rst deasserts: ctr_jmp=1, ctr_jmpLoc=RST_VEC, ctr_en=0; the next state is RUN.
REQ-019 ctr_* and irq_ack SHALL be combinational from state, stack and current inputs; stack, in_isr and FSM SHALL update on the same rising edge that ctr consumes the command.
REQ-020 In RUN, exactly one action SHALL be selected per cycle, in this priority order: halt_req > stall > irq (when in_isr=0) > ret_req > call_req > br_req > rewind > increment.
REQ-021 halt_req: ctr_en=0, ctr_jmp=0; the next state is HALT.
REQ-022 stall: ctr_en=0, ctr_jmp=0; no stack change; a pending irq is deferred, not lost.
REQ-023 irq: push {tag=1, pc_in+1}; ctr_jmp=1, ctr_jmpLoc=IRQ_VEC; irq_ack=1; set in_isr.
REQ-024 ret_req: pop the top entry; ctr_jmp=1, ctr_jmpLoc=popped address; if the popped tag=1, clear in_isr.
REQ-025 call_req: push {tag=0, pc_in+1}; ctr_jmp=1, ctr_jmpLoc=call_tgt.
REQ-026 br_req: ctr_jmp=1, ctr_jmpLoc=br_tgt; no stack change.
REQ-027 rewind: ctr_en=1, ctr_dir=0.
REQ-028 Default (increment): ctr_en=1, ctr_dir=1, ctr_jmp=0.
REQ-029 ctr_dir SHALL be 1 in every cycle except a rewind cycle.
REQ-030 When ctr_jmp=0, ctr_jmpLoc SHALL be 0.
REQ-031 pc_in+1 SHALL be computed modulo 2^AW: 10'h3FF+1 pushes 0.
REQ-032 irq or call with the stack full (DEPTH entries):
  - the push, jump and irq_ack are suppressed;
  - stk_err is set;
  - the cycle is treated as increment;
  - the irq remains pending.
REQ-033 ret_req with the stack empty: ignored (treated as increment); stk_err is set.
REQ-034 stk_err SHALL clear only on reset.
REQ-035 HALT: ctr_en=0, ctr_jmp=0, halted=1.
  - resume returns to RUN on the next cycle, with no ctr action in the resume cycle.
  - irq with in_isr=0 in HALT SHALL be taken exactly as in REQ-023, and the state returns to RUN.
  - halt_req in HALT has no effect.
REQ-036 Simultaneous requests SHALL perform only the winning action; losing requests are dropped, except irq, which is level-held by its source.

Reset
REQ-037 rst=0 SHALL immediately (asynchronously) force:
  - state=BOOT, stack pointer=0, in_isr=0, stk_err=0;
  - ctr_en=0, ctr_jmp=0, ctr_jmpLoc=0, ctr_dir=1;
  - irq_ack=0, halted=0.
REQ-038 Reset mid-operation (stall, HALT or ISR) SHALL discard all stack contents; the BOOT cycle SHALL follow the release of rst.

Verification
REQ-039 Boot: release rst -> one cycle with ctr_jmp=1, ctr_jmpLoc=0; then ctr_en=1, ctr_dir=1; pc_in counts 0,1,2,...
REQ-040 Call/return: at pc_in=5, call_req with call_tgt=69 -> jump to 69; ret_req at pc_in=72 -> ctr_jmpLoc=6, stack empty.
REQ-041 Interrupt:
  - irq at pc_in=10 together with br_req -> the branch is dropped; jump to 16; irq_ack pulses once.
  - irq held high during the ISR -> no re-entry.
  - ret -> jump to 11; in_isr=0.
REQ-042 Stack limits: five nested calls -> the 5th is ignored with stk_err=1; five rets -> the 5th is ignored; stk_err stays 1.
REQ-043 Halt/stall/rewind:
  - halt_req -> halted=1, pc_in frozen for 20 cycles; resume -> counting resumes.
  - stall and rewind both asserted -> ctr_en=0.
  - rewind alone at pc_in=0 -> ctr_dir=0, pc_in becomes 10'h3FF.
REQ-044 Reset inside the ISR with 3 stack entries -> all outputs at reset values; BOOT jump to 0; a subsequent ret sets stk_err=1.
